// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the unified instruction/data RAM arbiter.
//   - arb_state_t : 2-bit FSM encoding (IDLE, ISSUE, WAIT, RESP)
//   - req_id_t    : requester id (INSTR = 0, DATA = 1)
//   - lat_load()  : value loaded into the read-latency counter on issue
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MEM_ARB_IDLE  = 2'd0,
        MEM_ARB_ISSUE = 2'd1,
        MEM_ARB_WAIT  = 2'd2,
        MEM_ARB_RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        MEM_ARB_ID_INSTR = 1'b0,
        MEM_ARB_ID_DATA  = 1'b1
    } req_id_t;

    // Largest supported RAM read latency; sizes the latency counter.
    localparam int MEM_LAT_MAX = 3;
    localparam int LAT_CNT_W   = 2;

    // The counter counts down to zero, and the zero cycle is the capture
    // cycle, so MEM_LAT cycles of waiting need a start value of MEM_LAT-1.
    function automatic logic [LAT_CNT_W-1:0] lat_load(input int mem_lat);
        return LAT_CNT_W'(mem_lat - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port synchronous RAM between the instruction-fetch
//   requester and the data load/store requester. Exactly one transaction
//   is in flight: IDLE (arbitrate) -> ISSUE (RAM strobe, gnt pulse) ->
//   WAIT (RAM read latency) -> RESP (rvalid pulse) -> IDLE. Writes go from
//   ISSUE straight back to IDLE.
//
//   Handshake: a requester raises req, with its address/data stable, and
//   holds it until its gnt pulse. req is sampled only in IDLE. A write is
//   complete at gnt. A read returns rvalid (one cycle) MEM_LAT+1 cycles
//   after gnt, with rdata holding the word until the next response to the
//   same requester.
//
//   Parameters: ADDR_W  RAM word-address width (2**ADDR_W words of 32 bits)
//               MEM_LAT RAM read latency, 1..3 cycles
//
//   Ports:
//     clk, rst_n                         clock, synchronous active-low reset
//     i_req, i_addr                      instruction read request
//     i_gnt, i_rvalid, i_rdata           instruction grant / response
//     d_req, d_we, d_addr, d_wdata, d_wstrb   data request
//     d_gnt, d_rvalid, d_rdata           data grant / response
//     mem_en, mem_we, mem_wstrb, mem_addr, mem_wdata, mem_rdata   RAM side
//     busy                               high whenever the FSM is not in IDLE
//
//   Build option: MEM_ARB_RR_EN
//     defined   - round-robin on a conflict (the requester not granted last
//                 wins; last_grant resets to DATA so INSTR wins first)
//     undefined - fixed priority, data wins every conflict
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,

    output logic              busy
);

    localparam logic [LAT_CNT_W-1:0] LAT_START = lat_load(MEM_LAT);

    arb_state_t           state;
    req_id_t              lat_id;   // requester owning the transaction in flight
    logic                 lat_we;   // transaction in flight is a write
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic                 d_wins;

`ifdef MEM_ARB_RR_EN
    req_id_t              last_grant;
`endif

    // Byte-offset bits and bits above the RAM size are ignored by design:
    // addresses are word-aligned and wrap modulo the RAM size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    // Winner select for the IDLE sampling cycle.
    always_comb begin
        d_wins = d_req;
`ifdef MEM_ARB_RR_EN
        if (i_req && d_req) begin
            d_wins = (last_grant == MEM_ARB_ID_INSTR);
        end
`endif
    end

    // All outputs are registered: the RAM strobe and gnt for the ISSUE
    // cycle are loaded on the IDLE->ISSUE edge from the winner's inputs,
    // which doubles as the request latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= MEM_ARB_IDLE;
            lat_id    <= MEM_ARB_ID_INSTR;
            lat_we    <= 1'b0;
            lat_cnt   <= '0;
            i_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant <= MEM_ARB_ID_DATA;
`endif
        end else begin
            // Pulses and RAM strobes default low; only ISSUE/RESP raise them.
            i_gnt     <= 1'b0;
            d_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;

            case (state)
                MEM_ARB_IDLE: begin
                    if (i_req || d_req) begin
                        state  <= MEM_ARB_ISSUE;
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        if (d_wins) begin
                            lat_id    <= MEM_ARB_ID_DATA;
                            lat_we    <= d_we;
                            d_gnt     <= 1'b1;
                            mem_we    <= d_we;
                            mem_wstrb <= d_we ? d_wstrb : 4'b0000;
                            mem_addr  <= d_addr[ADDR_W+1:2];
                            mem_wdata <= d_wdata;
                        end else begin
                            lat_id    <= MEM_ARB_ID_INSTR;
                            lat_we    <= 1'b0;
                            i_gnt     <= 1'b1;
                            mem_addr  <= i_addr[ADDR_W+1:2];
                        end
`ifdef MEM_ARB_RR_EN
                        last_grant <= d_wins ? MEM_ARB_ID_DATA : MEM_ARB_ID_INSTR;
`endif
                    end
                end

                MEM_ARB_ISSUE: begin
                    if (lat_we) begin
                        state <= MEM_ARB_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state   <= MEM_ARB_WAIT;
                        lat_cnt <= LAT_START;
                    end
                end

                MEM_ARB_WAIT: begin
                    // mem_rdata is valid in the cycle the counter reaches zero.
                    if (lat_cnt == '0) begin
                        state <= MEM_ARB_RESP;
                        if (lat_id == MEM_ARB_ID_DATA) begin
                            d_rdata  <= mem_rdata;
                            d_rvalid <= 1'b1;
                        end else begin
                            i_rdata  <= mem_rdata;
                            i_rvalid <= 1'b1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                MEM_ARB_RESP: begin
                    state <= MEM_ARB_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= MEM_ARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Bench for mem_arbiter (ADDR_W=12, MEM_LAT=2) with a behavioural RAM.
//   Expected grant order, event cycles and read data come from a
//   transaction-level model: service order from the arbitration rule,
//   event cycles from the latency arithmetic, data from a word array
//   updated with byte-strobed writes in service order.
//   Honours MEM_ARB_RR_EN for the expected conflict order.
module tb_mem_arbiter;

    localparam int ADDR_W = 12;
    localparam int LAT    = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              busy;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1, "watchdog");
    end

    mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_wstrb (mem_wstrb),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // ---------------- behavioural RAM (latency LAT) ----------------
    logic [31:0] ram [0:DEPTH-1];
    logic [31:0] rd_pipe [0:LAT-1];

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_wstrb[k]) ram[mem_addr][8*k +: 8] = mem_wdata[8*k +: 8];
            end
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? ram[mem_addr] : 32'h0;
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    // ---------------- reference model ----------------
    logic [31:0]       model_mem [0:DEPTH-1];
    bit                model_last_d = 1'b1;
    logic [ADDR_W-1:0] last_mem_addr;
    logic [7:0]        ord_q[$];

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        for (int k = 0; k < 4; k++) begin
            if (st[k]) model_mem[widx(a)][8*k +: 8] = wd[8*k +: 8];
        end
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pulses"}, {27'd0, i_gnt, i_rvalid, d_gnt, d_rvalid, busy}, 32'd0);
        chk({tag, "_i_rdata"}, i_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
        chk({tag, "_mem_ctl"}, {18'd0, mem_en, mem_we, mem_wstrb, 8'd0}, 32'd0);
        chk({tag, "_mem_addr"}, {20'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    // One round: from an IDLE cycle, raise the requested req lines and check
    // every cycle until the arbiter is back in IDLE after serving them all.
    task automatic run_round(input bit want_i, input bit want_d, input logic [31:0] ia,
                             input bit dwe, input logic [31:0] da, input logic [31:0] dwd,
                             input logic [3:0] dst);
        int          t, n, nt, endc;
        int          g [2];
        int          r [2];
        int          e [2];
        bit          srv_d [2];
        bit          is_rd [2];
        logic [31:0] exp_rd [2];
        logic [31:0] exp_ad [2];
        bit          first_d;
        bit          e_ig, e_dg, e_ir, e_dr, e_busy;
        int          gk, rk;

        t = cyc;
        if (want_i && want_d) begin
`ifdef MEM_ARB_RR_EN
            first_d = !model_last_d;
`else
            first_d = 1'b1;
`endif
        end else begin
            first_d = want_d;
        end
        n = (want_i && want_d) ? 2 : 1;
        srv_d[0] = first_d;
        srv_d[1] = !first_d;
        nt = t;
        for (int k = 0; k < n; k++) begin
            g[k]      = nt + 1;
            is_rd[k]  = srv_d[k] ? !dwe : 1'b1;
            exp_ad[k] = widx(srv_d[k] ? da : ia);
            exp_rd[k] = 32'h0;
            if (is_rd[k]) begin
                r[k]      = g[k] + LAT + 1;
                e[k]      = r[k];
                exp_rd[k] = model_mem[widx(srv_d[k] ? da : ia)];
            end else begin
                r[k] = -1;
                e[k] = g[k];
                model_write(da, dwd, dst);
            end
            nt = e[k] + 1;
            model_last_d = srv_d[k];
        end
        endc = nt;

        i_req   = want_i;
        i_addr  = ia;
        d_req   = want_d;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
        d_wstrb = dst;

        for (int c = t; c < endc; c++) begin
            e_ig = 0; e_dg = 0; e_ir = 0; e_dr = 0; e_busy = 0; gk = -1; rk = -1;
            for (int k = 0; k < n; k++) begin
                if (c == g[k]) begin
                    gk = k;
                    if (srv_d[k]) e_dg = 1; else e_ig = 1;
                end
                if (c == r[k]) begin
                    rk = k;
                    if (srv_d[k]) e_dr = 1; else e_ir = 1;
                end
                if (c >= g[k] && c <= e[k]) e_busy = 1;
            end
            chk("i_gnt", i_gnt, e_ig);
            chk("d_gnt", d_gnt, e_dg);
            chk("i_rvalid", i_rvalid, e_ir);
            chk("d_rvalid", d_rvalid, e_dr);
            chk("busy", busy, e_busy);
            if (gk >= 0) begin
                chk("mem_en_issue", mem_en, 1'b1);
                chk("mem_addr", mem_addr, exp_ad[gk]);
                chk("mem_we", mem_we, !is_rd[gk]);
                chk("mem_wstrb", mem_wstrb, is_rd[gk] ? 4'b0000 : dst);
                if (!is_rd[gk]) chk("mem_wdata", mem_wdata, dwd);
                last_mem_addr = mem_addr;
            end else begin
                chk("mem_en_idle", mem_en, 1'b0);
            end
            if (rk >= 0) begin
                if (srv_d[rk]) chk("d_rdata", d_rdata, exp_rd[rk]);
                else           chk("i_rdata", i_rdata, exp_rd[rk]);
            end
            if (i_gnt) begin
                ord_q.push_back("I");
                i_req = 1'b0;
            end
            if (d_gnt) begin
                ord_q.push_back("D");
                d_req = 1'b0;
            end
            next_cycle();
        end
    endtask

    // ---------------- test sequence ----------------
    logic [7:0] exp_ord [6];

    initial begin
        logic [31:0] w;
        logic [1:0]  sel;

        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            ram[i]       = w;
            model_mem[i] = w;
        end
        for (int k = 0; k < LAT; k++) rd_pipe[k] = 32'h0;

        rst_n = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_wstrb = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        next_cycle();

        // Conflicts: both requesters held until served, three rounds.
        ord_q.delete();
        for (int k = 0; k < 3; k++) begin
            run_round(1'b1, 1'b1, 32'h200 + 32'(k*4), 1'b0, 32'h300 + 32'(k*4), 32'h0, 4'h0);
        end
`ifdef MEM_ARB_RR_EN
        exp_ord = '{"I", "D", "I", "D", "I", "D"};
`else
        exp_ord = '{"D", "I", "D", "I", "D", "I"};
`endif
        chk("grant_order_len", ord_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < ord_q.size()) chk("grant_order", ord_q[k], exp_ord[k]);
        end

        // Instruction read of word 4.
        ram[4] = 32'hDEADBEEF;
        model_mem[4] = 32'hDEADBEEF;
        run_round(1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("instr_read_data", i_rdata, 32'hDEADBEEF);
        chk("instr_read_addr", last_mem_addr, 12'd4);

        // Partial write to a zeroed word, then read it back.
        ram[8] = 32'h0;
        model_mem[8] = 32'h0;
        run_round(1'b0, 1'b1, 32'h0, 1'b1, 32'h20, 32'h12345678, 4'b0011);
        chk("write_addr", last_mem_addr, 12'd8);
        run_round(1'b0, 1'b1, 32'h0, 1'b0, 32'h20, 32'hFFFFFFFF, 4'hF);
        chk("write_readback", d_rdata, 32'h00005678);
        chk("i_rdata_held", i_rdata, 32'hDEADBEEF);

        // Low byte-offset bits dropped; upper bits wrap.
        run_round(1'b1, 1'b0, 32'h13, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("addr_low_drop", last_mem_addr, 12'd4);
        run_round(1'b1, 1'b0, 32'h4010, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("addr_wrap", last_mem_addr, 12'd4);

        // i_req held high: one read every LAT+3 cycles.
        i_req  = 1'b1;
        i_addr = 32'h100;
        for (int k = 0; k <= 3*(LAT+3); k++) begin
            chk("b2b_i_rvalid", i_rvalid, (k % (LAT+3)) == LAT+2);
            chk("b2b_busy", busy, (k % (LAT+3)) != 0);
            if (i_rvalid) chk("b2b_i_rdata", i_rdata, model_mem[widx(32'h100)]);
            if (k == 3*(LAT+3) - 1) i_req = 1'b0;
            next_cycle();
        end
        model_last_d = 1'b0;

        // Randomized rounds against the model.
        for (int k = 0; k < 40; k++) begin
            sel = 2'($urandom_range(1, 3));
            run_round(sel[0], sel[1], $urandom & 32'hFFFF_C03F, 1'($urandom_range(0, 1)),
                      $urandom & 32'hFFFF_C03F, $urandom, 4'($urandom_range(0, 15)));
        end

        // Reset during the second WAIT cycle of a read.
        i_req  = 1'b1;
        i_addr = 32'h40;
        next_cycle();
        chk("rst_case_gnt", i_gnt, 1'b1);
        i_req = 1'b0;
        next_cycle();
        chk("rst_case_busy", busy, 1'b1);
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        chk_all_zero("mid_wait_reset");
        rst_n = 1'b1;
        model_last_d = 1'b1;
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            chk("no_rvalid_after_reset", {30'd0, i_rvalid, d_rvalid}, 32'd0);
            chk("i_rdata_after_reset", i_rdata, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
